// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry, pointer type
// and Gray-code helpers used by both the write and read controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[FIFO_ADDR_W] = gray[FIFO_ADDR_W];
    for (int i = FIFO_ADDR_W - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock.
// Cleared by the shared asynchronous active-low reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the 8-deep dual-clock FIFO: handshake, write port,
// pointers and conservative full/level flags. Optional checker: FIFO_WR_PTR_CHECK_EN.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int AF_THRESH = 6
) (
  input  logic              wclk,
  input  logic              nRst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W:0]   rptr_gray_in,
  output logic [ADDR_W:0]   wptr_gray_out,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level
`ifdef FIFO_WR_PTR_CHECK_EN
  ,
  output logic              err_ptr
`endif
);

  localparam int              DEPTH_L = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH_L);
  localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] ONE_P   = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] wptr_bin_reg;
  logic [ADDR_W:0] wptr_gray_reg;
  logic [ADDR_W:0] wptr_bin_next;
  logic [ADDR_W:0] wptr_gray_next;
  logic [ADDR_W:0] rq2;
  logic [ADDR_W:0] rbin_s;
  logic            wr_en;

  sync_2ff #(
    .WIDTH (ADDR_W + 1)
  ) u_rptr_sync (
    .clk  (wclk),
    .nRst (nRst),
    .d    (rptr_gray_in),
    .q    (rq2)
  );

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ADDR_W; gi++) begin : g_gray2bin
    assign rbin_s[gi] = ^rq2[ADDR_W:gi];
  end

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full        = (wptr_gray_reg == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]});
  assign wr_level    = wptr_bin_reg - rbin_s;
  assign almost_full = (wr_level >= AF_LVL);
  assign s_ready     = !full;

  // Gate with nRst so an in-flight word is never written while reset is held.
  assign wr_en     = s_valid && s_ready && nRst;
  assign mem_we    = wr_en;
  assign mem_waddr = wptr_bin_reg[ADDR_W-1:0];
  assign mem_wdata = s_data;

  assign wptr_bin_next  = wptr_bin_reg + ONE_P;
  assign wptr_gray_next = wptr_bin_next ^ (wptr_bin_next >> 1);
  assign wptr_gray_out  = wptr_gray_reg;

  always_ff @(posedge wclk or negedge nRst) begin
    if (!nRst) begin
      wptr_bin_reg  <= '0;
      wptr_gray_reg <= '0;
    end else if (wr_en) begin
      wptr_bin_reg  <= wptr_bin_next;
      wptr_gray_reg <= wptr_gray_next;
    end
  end

`ifdef FIFO_WR_PTR_CHECK_EN
  logic [ADDR_W:0] rq2_prev_reg;
  logic [ADDR_W:0] rq2_delta;
  logic            err_reg;
  logic            err_now;

  // A legal Gray stream never flips more than one bit between samples.
  assign rq2_delta = rq2 ^ rq2_prev_reg;
  assign err_now   = (|(rq2_delta & (rq2_delta - ONE_P))) || (wr_level > DEPTH_P);
  assign err_ptr   = err_reg || err_now;

  always_ff @(posedge wclk or negedge nRst) begin
    if (!nRst) begin
      rq2_prev_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      rq2_prev_reg <= rq2;
      if (err_now) begin
        err_reg <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge wclk) begin
    if (nRst) begin
      assert (!err_now)
      else $warning("async_fifo_wr_ctrl: read pointer step or level out of range (rq2=%0h level=%0d)",
                    rq2, wr_level);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl: fill, drain-while-full, reset mid-stream,
// almost_full threshold and pointer wrap, with hand-computed expectations.
module tb_async_fifo_wr_ctrl;

  logic       wclk;
  logic       nRst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [3:0] rptr_gray_in;
  logic [3:0] wptr_gray_out;
  logic       mem_we;
  logic [2:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
`ifdef FIFO_WR_PTR_CHECK_EN
  logic       err_ptr;
`endif

  int n_vec;
  int n_err;

  // Gray codes of 0..15, written out by hand.
  logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  async_fifo_wr_ctrl dut (
    .wclk          (wclk),
    .nRst          (nRst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .rptr_gray_in  (rptr_gray_in),
    .wptr_gray_out (wptr_gray_out),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .full          (full),
    .almost_full   (almost_full),
    .wr_level      (wr_level)
`ifdef FIFO_WR_PTR_CHECK_EN
    ,
    .err_ptr       (err_ptr)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, ".full"}, 32'(full), 32'd0);
    chk({tag, ".almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, ".wr_level"}, 32'(wr_level), 32'd0);
    chk({tag, ".wptr_gray"}, 32'(wptr_gray_out), 32'd0);
  endtask

  // Assert reset away from the clock edge, check it across two edges, release.
  task automatic do_reset(input string tag);
    nRst = 1'b0;
    rptr_gray_in = 4'd0;
    #1;
    chk_idle_reset(tag);
    tick();
    chk({tag, ".hold1.mem_we"}, 32'(mem_we), 32'd0);
    tick();
    chk({tag, ".hold2.mem_we"}, 32'(mem_we), 32'd0);
    nRst = 1'b1;
    #1;
  endtask

  initial begin
    logic [3:0] prev_gray;
    int         exp_lvl;
    n_vec = 0;
    n_err = 0;
    nRst = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    rptr_gray_in = 4'd0;
    tick();
    chk_idle_reset("rst");
    s_valid = 1'b1;
    #1;
    chk("rst.valid_mem_we", 32'(mem_we), 32'd0);
    tick();
    nRst = 1'b1;
    #1;

    // Fill from empty with the read pointer parked at 0.
    for (int i = 0; i < 10; i++) begin
      s_data = 8'hA0 + 8'(i);
      #1;
      exp_lvl = (i < 8) ? i : 8;
      chk($sformatf("fill%0d.mem_we", i), 32'(mem_we), (i < 8) ? 32'd1 : 32'd0);
      if (i < 8) begin
        chk($sformatf("fill%0d.waddr", i), 32'(mem_waddr), 32'(i));
        chk($sformatf("fill%0d.wdata", i), 32'(mem_wdata), 32'(8'hA0 + 8'(i)));
      end
      chk($sformatf("fill%0d.full", i), 32'(full), (i >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.s_ready", i), 32'(s_ready), (i >= 8) ? 32'd0 : 32'd1);
      chk($sformatf("fill%0d.level", i), 32'(wr_level), 32'(exp_lvl));
      chk($sformatf("fill%0d.af", i), 32'(almost_full), (exp_lvl >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.gray", i), 32'(wptr_gray_out), 32'(gray_tbl[exp_lvl]));
      tick();
    end
    chk("fill.final_gray", 32'(wptr_gray_out), 32'b1100);

    // Drain one entry while full: read pointer 0 -> 1.
    s_data = 8'h5C;
    rptr_gray_in = 4'd1;
    #1;
    chk("drain.e0.full", 32'(full), 32'd1);
    chk("drain.e0.mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("drain.e1.full", 32'(full), 32'd1);
    chk("drain.e1.mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("drain.e2.full", 32'(full), 32'd0);
    chk("drain.e2.level", 32'(wr_level), 32'd7);
    chk("drain.e2.mem_we", 32'(mem_we), 32'd1);
    chk("drain.e2.waddr", 32'(mem_waddr), 32'd0);
    chk("drain.e2.wdata", 32'(mem_wdata), 32'h5C);
    tick();
    chk("drain.e3.full", 32'(full), 32'd1);
    chk("drain.e3.level", 32'(wr_level), 32'd8);
    chk("drain.e3.mem_we", 32'(mem_we), 32'd0);
    chk("drain.e3.gray", 32'(wptr_gray_out), 32'd13);

    // Reset while s_valid is still high.
    do_reset("midrst");
    chk("midrst.resume.mem_we", 32'(mem_we), 32'd1);
    chk("midrst.resume.waddr", 32'(mem_waddr), 32'd0);

    // almost_full rises exactly after the 6th write.
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("af6.w%0d.waddr", i), 32'(mem_waddr), 32'(i));
      chk($sformatf("af6.w%0d.af", i), 32'(almost_full), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("af6.af", 32'(almost_full), 32'd1);
    chk("af6.level", 32'(wr_level), 32'd6);
    do_reset("af5rst");
    s_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) tick();
    s_valid = 1'b0;
    #1;
    chk("af5.af", 32'(almost_full), 32'd0);
    chk("af5.level", 32'(wr_level), 32'd5);
    tick();
    chk("af5.hold.level", 32'(wr_level), 32'd5);

    // Wrap: three rounds of 8 writes, each followed by a one-step-at-a-time drain.
    do_reset("wraprst");
    for (int r = 0; r < 3; r++) begin
      s_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        s_data = 8'(r * 8 + k);
        #1;
        chk($sformatf("wrap%0d.%0d.mem_we", r, k), 32'(mem_we), 32'd1);
        chk($sformatf("wrap%0d.%0d.waddr", r, k), 32'(mem_waddr), 32'(k));
        chk($sformatf("wrap%0d.%0d.level", r, k), 32'(wr_level), 32'(k));
        chk($sformatf("wrap%0d.%0d.gray", r, k), 32'(wptr_gray_out), 32'(gray_tbl[(r * 8 + k) % 16]));
        prev_gray = wptr_gray_out;
        tick();
        chk($sformatf("wrap%0d.%0d.onebit", r, k), 32'($countones(wptr_gray_out ^ prev_gray)), 32'd1);
      end
      chk($sformatf("wrap%0d.full", r), 32'(full), 32'd1);
      chk($sformatf("wrap%0d.level8", r), 32'(wr_level), 32'd8);
      chk($sformatf("wrap%0d.blocked", r), 32'(mem_we), 32'd0);
      s_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        rptr_gray_in = gray_tbl[(r * 8 + k) % 16];
        tick();
        chk($sformatf("wrap%0d.rd%0d.lvl_le8", r, k), 32'(wr_level <= 4'd8), 32'd1);
      end
      tick();
      tick();
      chk($sformatf("wrap%0d.empty", r), 32'(wr_level), 32'd0);
      chk($sformatf("wrap%0d.notfull", r), 32'(full), 32'd0);
    end
    chk("wrap.end_gray", 32'(wptr_gray_out), 32'd12);

`ifdef FIFO_WR_PTR_CHECK_EN
    // Illegal two-bit jump on the read pointer sets the sticky error.
    do_reset("errrst");
    chk("err.after_reset", 32'(err_ptr), 32'd0);
    rptr_gray_in = 4'd3;
    tick();
    chk("err.edge1", 32'(err_ptr), 32'd0);
    tick();
    chk("err.edge2", 32'(err_ptr), 32'd1);
    rptr_gray_in = 4'd0;
    for (int i = 0; i < 4; i++) tick();
    chk("err.sticky", 32'(err_ptr), 32'd1);
    nRst = 1'b0;
    #1;
    chk("err.cleared", 32'(err_ptr), 32'd0);
    tick();
    nRst = 1'b1;
    #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
